// File: rtl/hacd_pkg.sv
// rtl/hacd_pkg.sv - shared types and constants for the hawk read-channel arbiter
package hacd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_arb_state_t;

  localparam int RDARB_MAIN   = 0;
  localparam int RDARB_COMP   = 1;
  localparam int RDARB_DECOMP = 2;
  localparam int RDARB_CMPT   = 3;

  typedef struct packed {
    logic len_err;
    logic resp_err;
    logic timeout;
  } rd_arb_sts_t;

  // Index width that stays legal for a single-requester build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hawk_rr_arbiter.sv
// rtl/hawk_rr_arbiter.sv - combinational round-robin picker
// Searches from ptr_i+1 upward, wrapping, and returns the first set request.
module hawk_rr_arbiter
  import hacd_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  int            s;
  logic [IW-1:0] k;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    s         = 0;
    k         = '0;
    for (int i = 1; i <= N; i++) begin
      s = int'(ptr_i) + i;
      if (s >= N) s = s - N;
      k = IW'(s);
      if (!any_o && req_i[k]) begin
        any_o       = 1'b1;
        gnt_oh_o[k] = 1'b1;
        gnt_idx_o   = k;
      end
    end
  end

endmodule

// File: rtl/hawk_axi_rd_arb.sv
// rtl/hawk_axi_rd_arb.sv - round-robin arbiter sharing one AXI4 read master
// One burst outstanding at a time; R beats are routed back to the granted requester.
module hawk_axi_rd_arb
  import hacd_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int ADDR_W      = 64,
  parameter  int DATA_W      = 512,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int IW          = idx_w(NUM_REQ),
  localparam int WD_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_arvalid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*8-1:0]      req_arlen_i,
  output logic [NUM_REQ-1:0]        req_arready_o,
  output logic [NUM_REQ-1:0]        req_rvalid_o,
  input  logic [NUM_REQ-1:0]        req_rready_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [1:0]                rresp_o,
  output logic                      rlast_o,
  output logic                      m_arvalid_o,
  output logic [ADDR_W-1:0]         m_araddr_o,
  output logic [7:0]                m_arlen_o,
  input  logic                      m_arready_i,
  input  logic                      m_rvalid_i,
  input  logic [DATA_W-1:0]         m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rlast_i,
  output logic                      m_rready_o,
  output logic [IW-1:0]             grant_o,
  output logic                      busy_o,
  input  logic                      clr_err_i,
  output logic                      len_err_o,
  output logic                      resp_err_o,
  output logic                      timeout_o
);

  rd_arb_state_t     state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, grant_q, grant_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d, beat_q, beat_d;
  logic              arvalid_q, arvalid_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  rd_arb_sts_t       sts_q, sts_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               ar_hs, r_hs, stall;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [7:0]         len_arr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
    assign len_arr[gi]  = req_arlen_i[gi*8 +: 8];
  end

  hawk_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i     (req_arvalid_i),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  assign ar_hs = (state_q == ADDR) && m_arready_i;
  assign r_hs  = (state_q == DATA) && m_rvalid_i && m_rready_o;
  assign stall = (state_q != IDLE) && !ar_hs && !r_hs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = ADDR;
      ADDR:    if (m_arready_i) state_d = DATA;
      DATA:    if (r_hs && m_rlast_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_arready_o = '0;
    req_rvalid_o  = '0;
    m_rready_o    = 1'b0;
    rdata_o       = '0;
    rresp_o       = '0;
    rlast_o       = 1'b0;
    if (state_q == IDLE && !rst_i) req_arready_o = arb_oh;
    if (state_q == DATA) begin
      m_rready_o            = req_rready_i[grant_q];
      req_rvalid_o[grant_q] = m_rvalid_i;
      rdata_o               = m_rdata_i;
      rresp_o               = m_rresp_i;
      rlast_o               = m_rlast_i;
    end
  end

  always_comb begin
    ptr_d          = ptr_q;
    grant_d        = grant_q;
    araddr_d       = araddr_q;
    arlen_d        = arlen_q;
    arvalid_d      = arvalid_q;
    beat_d         = beat_q;
    sts_d.len_err  = sts_q.len_err  & ~clr_err_i;
    sts_d.resp_err = sts_q.resp_err & ~clr_err_i;
    sts_d.timeout  = sts_q.timeout  & ~clr_err_i;
    wdog_d         = '0;
    if (stall) begin
      if (wdog_q != WD_W'(TIMEOUT_CYC)) wdog_d = wdog_q + 1'b1;
      else                              wdog_d = wdog_q;
      if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) sts_d.timeout = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          araddr_d  = addr_arr[arb_idx];
          arlen_d   = len_arr[arb_idx];
          arvalid_d = 1'b1;
          grant_d   = arb_idx;
        end
      end
      ADDR: begin
        if (m_arready_i) begin
          arvalid_d = 1'b0;
          beat_d    = '0;
        end
      end
      DATA: begin
        if (r_hs) begin
          if (beat_q != 8'hFF) beat_d = beat_q + 8'd1;
          // Error on early rlast, and equally on a missing rlast at the final beat.
          if (m_rlast_i != (beat_q == arlen_q)) sts_d.len_err = 1'b1;
          if (m_rresp_i != 2'b00) sts_d.resp_err = 1'b1;
          if (m_rlast_i) ptr_d = grant_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q     <= IW'(NUM_REQ - 1);
      grant_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      beat_q    <= '0;
      wdog_q    <= '0;
      sts_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      beat_q    <= beat_d;
      wdog_q    <= wdog_d;
      sts_q     <= sts_d;
    end
  end

  assign m_arvalid_o = arvalid_q;
  assign m_araddr_o  = araddr_q;
  assign m_arlen_o   = arlen_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != IDLE);
  assign len_err_o   = sts_q.len_err;
  assign resp_err_o  = sts_q.resp_err;
  assign timeout_o   = sts_q.timeout;

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// tb/tb_hawk_axi_rd_arb.sv - scoreboard bench for hawk_axi_rd_arb
module tb_hawk_axi_rd_arb;
  import hacd_pkg::*;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_arvalid_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*8-1:0]  req_arlen_i;
  logic [N-1:0]    req_arready_o, req_rvalid_o, req_rready_i;
  logic [DW-1:0]   rdata_o, m_rdata_i;
  logic [1:0]      rresp_o, m_rresp_i;
  logic            rlast_o, m_arvalid_o, m_arready_i, m_rvalid_i, m_rlast_i, m_rready_o;
  logic [AW-1:0]   m_araddr_o;
  logic [7:0]      m_arlen_o;
  logic [1:0]      grant_o;
  logic            busy_o, clr_err_i, len_err_o, resp_err_o, timeout_o;

  always #5 clk = ~clk;

  hawk_axi_rd_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_arvalid_i(req_arvalid_i), .req_addr_i(req_addr_i), .req_arlen_i(req_arlen_i),
    .req_arready_o(req_arready_o), .req_rvalid_o(req_rvalid_o), .req_rready_i(req_rready_i),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .m_arvalid_o(m_arvalid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
    .m_arready_i(m_arready_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i), .m_rready_o(m_rready_o),
    .grant_o(grant_o), .busy_o(busy_o), .clr_err_i(clr_err_i),
    .len_err_o(len_err_o), .resp_err_o(resp_err_o), .timeout_o(timeout_o)
  );

  typedef struct { int idx; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { int idx; logic [DW-1:0] data; } bt_t;
  ar_t exp_ar[$];
  bt_t exp_beat[$];

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a, input int b);
    logic [DW-1:0] d;
    d = '0;
    d[AW-1:0]      = a;
    d[AW+15:AW]    = 16'(b);
    d[DW-1 -: 32]  = 32'hC0DE_0000 ^ 32'(b);
    return d;
  endfunction

  // Slave knobs and state
  int            sl_state = 0, sl_beat = 0;
  logic [AW-1:0] sl_addr = '0;
  logic [7:0]    sl_len = '0;
  int            last_beat = -1, bad_resp_beat = -1;
  bit            ar_hold = 0, toggle_en = 0;

  // Values sampled at the falling edge
  bit            s_ar_hs = 0, s_r_hs = 0, s_rlast = 0;
  logic [AW-1:0] s_addr = '0;
  logic [7:0]    s_len = '0;
  logic [N-1:0]  s_acc = '0;
  int            beats_seen = 0;

  always @(negedge clk) begin
    ar_t e;
    bt_t b;
    s_acc   = req_arready_o & req_arvalid_i;
    s_ar_hs = m_arvalid_o & m_arready_i;
    s_addr  = m_araddr_o;
    s_len   = m_arlen_o;
    s_r_hs  = m_rvalid_i & m_rready_o;
    s_rlast = m_rlast_i;
    if (!rst_i && s_ar_hs) begin
      if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
      else begin
        e = exp_ar.pop_front();
        chk("ar_grant", grant_o, e.idx);
        chk("ar_addr", m_araddr_o, e.addr);
        chk("ar_len", m_arlen_o, e.len);
      end
    end
    if (!rst_i && (req_rvalid_o & req_rready_i) != '0) begin
      beats_seen++;
      if (exp_beat.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        b = exp_beat.pop_front();
        chk("beat_route", req_rvalid_o, N'(1) << b.idx);
        chk("beat_data", rdata_o, b.data);
      end
    end
    if (!rst_i && toggle_en && m_rvalid_i) chk("rready_mirror", m_rready_o, req_rready_i[2]);
  end

  // Slave and requester-drop driver
  initial begin
    m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = 2'b00; m_rlast_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_i) sl_state = 0;
      else begin
        req_arvalid_i = req_arvalid_i & ~s_acc;
        if (s_ar_hs) begin
          sl_state = 1; sl_addr = s_addr; sl_len = s_len; sl_beat = 0;
        end else if (sl_state == 1 && s_r_hs) begin
          if (s_rlast) sl_state = 0;
          else sl_beat++;
        end
        if (toggle_en) req_rready_i[2] = ~req_rready_i[2];
      end
      m_arready_i = !ar_hold;
      m_rvalid_i  = (sl_state == 1);
      m_rdata_i   = mkdata(sl_addr, sl_beat);
      m_rlast_i   = (sl_state == 1) && (sl_beat == ((last_beat >= 0) ? last_beat : int'(sl_len)));
      m_rresp_i   = (sl_state == 1 && sl_beat == bad_resp_beat) ? 2'd2 : 2'd0;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int i, input logic [AW-1:0] a, input logic [7:0] l);
    req_addr_i[i*AW +: AW] = a;
    req_arlen_i[i*8 +: 8]  = l;
    req_arvalid_i[i]       = 1'b1;
  endtask

  task automatic exp_burst(input int i, input logic [AW-1:0] a, input logic [7:0] l, input int nb);
    ar_t e;
    bt_t b;
    e.idx = i; e.addr = a; e.len = l;
    exp_ar.push_back(e);
    for (int k = 0; k < nb; k++) begin
      b.idx = i; b.data = mkdata(a, k);
      exp_beat.push_back(b);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy_o || req_arvalid_i != '0 || exp_beat.size() != 0) && n < 600) begin
      cyc(); n++;
    end
    cyc();
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_beats_left"}, exp_beat.size(), 0);
    chk({tag, "_ars_left"}, exp_ar.size(), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_arvalid_i = '0;
    repeat (2) cyc();
    exp_ar.delete();
    exp_beat.delete();
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic clr_pulse();
    clr_err_i = 1'b1;
    cyc();
    clr_err_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int n, base;
    rst_i = 1'b1; req_arvalid_i = '1; req_addr_i = '0; req_arlen_i = '0;
    req_rready_i = '1; clr_err_i = 1'b0;
    repeat (3) cyc();
    chk("rst_arready", req_arready_o, 0);
    chk("rst_arvalid", m_arvalid_o, 0);
    chk("rst_araddr", m_araddr_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rready", m_rready_o, 0);
    chk("rst_errs", {len_err_o, resp_err_o, timeout_o}, 0);
    req_arvalid_i = '0;
    rst_i = 1'b0;
    cyc();

    // Single one-beat burst from the main FSM
    issue(RDARB_MAIN, 64'hFFF8_0000_0040, 8'd0);
    exp_burst(RDARB_MAIN, 64'hFFF8_0000_0040, 8'd0, 1);
    #1;
    chk("t1_arready_same_cycle", req_arready_o, 4'b0001);
    chk("t1_arvalid_before", m_arvalid_o, 0);
    @(posedge clk); #1;
    chk("t1_arvalid_next", m_arvalid_o, 1);
    chk("t1_busy", busy_o, 1);
    wait_idle("t1");
    chk("t1_errs", {len_err_o, resp_err_o, timeout_o}, 0);

    // All four at once after reset: 0,1,2,3
    do_reset();
    for (int i = 0; i < N; i++) begin
      issue(i, 64'h1000_0000 + 64'(i) * 64'h100, 8'd3);
      exp_burst(i, 64'h1000_0000 + 64'(i) * 64'h100, 8'd3, 4);
    end
    wait_idle("t2");

    // req1 and req3 after reset, req1 re-requests: 1,3,1
    do_reset();
    issue(1, 64'h2000, 8'd1);
    issue(3, 64'h3000, 8'd1);
    exp_burst(1, 64'h2000, 8'd1, 2);
    exp_burst(3, 64'h3000, 8'd1, 2);
    exp_burst(1, 64'h2100, 8'd2, 3);
    n = 0;
    while (req_arvalid_i[1] && n < 50) begin cyc(); n++; end
    chk("t3_req1_accepted", req_arvalid_i[1], 0);
    issue(1, 64'h2100, 8'd2);
    wait_idle("t3");

    // Backpressure on requester 2
    toggle_en = 1;
    issue(2, 64'h4000, 8'd7);
    exp_burst(2, 64'h4000, 8'd7, 8);
    wait_idle("t4");
    toggle_en = 0;
    req_rready_i = '1;
    chk("t4_errs", {len_err_o, resp_err_o}, 0);

    // Early rlast
    last_beat = 2;
    issue(0, 64'h5000, 8'd3);
    exp_burst(0, 64'h5000, 8'd3, 3);
    wait_idle("t5a");
    chk("t5a_len_err", len_err_o, 1);
    last_beat = -1;
    clr_pulse();
    chk("t5a_len_err_clr", len_err_o, 0);

    // Missing rlast at the expected final beat
    last_beat = 2;
    issue(1, 64'h5100, 8'd1);
    exp_burst(1, 64'h5100, 8'd1, 3);
    wait_idle("t5b");
    chk("t5b_len_err", len_err_o, 1);
    last_beat = -1;
    clr_pulse();

    // Error response on one beat
    bad_resp_beat = 1;
    issue(3, 64'h5200, 8'd2);
    exp_burst(3, 64'h5200, 8'd2, 3);
    wait_idle("t5c");
    chk("t5c_resp_err", resp_err_o, 1);
    chk("t5c_len_err", len_err_o, 0);
    bad_resp_beat = -1;
    clr_pulse();
    chk("t5c_resp_err_clr", resp_err_o, 0);

    // AR stall past the watchdog limit
    ar_hold = 1;
    issue(0, 64'h6000, 8'd1);
    exp_burst(0, 64'h6000, 8'd1, 2);
    repeat (TO - 8) cyc();
    chk("t6_timeout_early", timeout_o, 0);
    chk("t6_busy", busy_o, 1);
    repeat (16) cyc();
    chk("t6_timeout", timeout_o, 1);
    chk("t6_arvalid_held", m_arvalid_o, 1);
    ar_hold = 0;
    wait_idle("t6");
    chk("t6_timeout_sticky", timeout_o, 1);
    clr_pulse();
    chk("t6_timeout_clr", timeout_o, 0);

    // Reset in the middle of a 4-beat burst
    issue(1, 64'h7000, 8'd3);
    exp_burst(1, 64'h7000, 8'd3, 4);
    base = beats_seen;
    n = 0;
    while (beats_seen - base < 2 && n < 50) begin cyc(); n++; end
    chk("t7_two_beats", (beats_seen - base) >= 2, 1);
    rst_i = 1'b1;
    #1;
    chk("t7_arvalid", m_arvalid_o, 0);
    chk("t7_rvalid", req_rvalid_o, 0);
    chk("t7_rready", m_rready_o, 0);
    chk("t7_busy", busy_o, 0);
    chk("t7_grant", grant_o, 0);
    chk("t7_araddr", m_araddr_o, 0);
    chk("t7_rdata", rdata_o, 0);
    req_arvalid_i = '0;
    repeat (2) cyc();
    exp_ar.delete();
    exp_beat.delete();
    rst_i = 1'b0;
    cyc();
    issue(0, 64'h8000, 8'd0);
    issue(1, 64'h8100, 8'd0);
    exp_burst(0, 64'h8000, 8'd0, 1);
    exp_burst(1, 64'h8100, 8'd0, 1);
    wait_idle("t7");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
